// File: rtl/character_pkg.sv
// Shared types and constants for the per-character action/motion controller.
package character_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WALK_L  = 3'd1,
        WALK_R  = 3'd2,
        ATTACK  = 3'd3,
        RECOVER = 3'd4,
        DEFEND  = 3'd5
    } state_t;

    localparam int unsigned SCREEN_W = 640;
    localparam int unsigned SPRITE_W = 64;

    // One walking step in either direction, clamped to [lo, hi] without wrapping.
    function automatic logic [9:0] step_sat(input logic [9:0] pos, input logic [9:0] step,
                                            input logic [9:0] lo, input logic [9:0] hi,
                                            input logic dir_right);
        logic [10:0] sum;
        sum = {1'b0, pos} + {1'b0, step};
        if (dir_right) begin
            if (sum > {1'b0, hi}) begin
                step_sat = hi;
            end else begin
                step_sat = sum[9:0];
            end
        end else begin
            if ({1'b0, pos} < ({1'b0, lo} + {1'b0, step})) begin
                step_sat = lo;
            end else begin
                step_sat = pos - step;
            end
        end
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Synchronises the asynchronous frame strobe and emits a one-clock pulse per rising edge.
module frame_tick_gen (
    input  logic clk,
    input  logic reset,
    input  logic frame_clk,
    output logic frame_tick
);

    logic sync1_r;
    logic sync2_r;
    logic prev_r;
    logic tick_r;

    // Two-flop synchroniser followed by a registered rising-edge detector.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            prev_r  <= 1'b0;
            tick_r  <= 1'b0;
        end else begin
            sync1_r <= frame_clk;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
            tick_r  <= sync2_r & ~prev_r;
        end
    end

    assign frame_tick = tick_r;

endmodule

// File: rtl/character_fsm.sv
// Per-character action/motion controller, advanced once per video frame.
// Optional DEFEND state is enabled by defining CHARACTER_DEFENSE_EN.
module character_fsm
    import character_pkg::*;
#(
    parameter logic [9:0] X_INIT         = 10'd160,
    parameter logic [9:0] X_MIN          = 10'd0,
    parameter logic [9:0] X_MAX          = 10'(SCREEN_W - SPRITE_W),
    parameter logic [9:0] STEP           = 10'd4,
    parameter logic [3:0] ATTACK_FRAMES  = 4'd8,
    parameter logic [3:0] HIT_FRAME      = 4'd3,
    parameter logic [3:0] RECOVER_FRAMES = 4'd6,
    parameter logic       FACE_INIT      = 1'b1
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic       move_l,
    input  logic       move_r,
    input  logic       attack,
    input  logic       defense,
    output logic [9:0] pos_x,
    output logic       facing,
    output logic [2:0] state,
    output logic [2:0] anim_frame,
    output logic       hit_active,
    output logic       blocking
);

    logic       tick_s;
    logic       defense_en_s;

    state_t     state_r;
    state_t     state_n;
    logic [9:0] pos_r;
    logic [9:0] pos_n;
    logic       facing_r;
    logic       facing_n;
    logic [3:0] cnt_r;
    logic [3:0] cnt_n;
    logic       armed_r;
    logic       armed_n;
    logic [2:0] anim_r;
    logic [2:0] anim_n;
    logic       hit_r;
    logic       hit_n;
    logic       block_r;
    logic       block_n;
    logic       decide_s;

    frame_tick_gen u_tick (
        .clk        (Clk),
        .reset      (Reset),
        .frame_clk  (frame_clk),
        .frame_tick (tick_s)
    );

`ifdef CHARACTER_DEFENSE_EN
    assign defense_en_s = defense;
`else
    logic defense_unused_s;
    assign defense_unused_s = defense;
    assign defense_en_s     = 1'b0;
`endif

    // Next-frame values; only committed on a frame tick.
    always_comb begin
        state_n  = state_r;
        pos_n    = pos_r;
        facing_n = facing_r;
        cnt_n    = cnt_r;
        armed_n  = attack ? armed_r : 1'b1;
        decide_s = 1'b0;

        case (state_r)
            ATTACK: begin
                if (cnt_r == (ATTACK_FRAMES - 4'd1)) begin
                    state_n = RECOVER;
                    cnt_n   = 4'd0;
                end else begin
                    cnt_n = cnt_r + 4'd1;
                end
            end
            RECOVER: begin
                if (cnt_r == (RECOVER_FRAMES - 4'd1)) begin
                    decide_s = 1'b1;
                end else begin
                    cnt_n = cnt_r + 4'd1;
                end
            end
            default: decide_s = 1'b1;
        endcase

        // Decision table: attack beats defense beats a single held direction.
        if (decide_s) begin
            if (attack && armed_r) begin
                state_n = ATTACK;
                cnt_n   = 4'd0;
                armed_n = 1'b0;
            end else if (defense_en_s) begin
                state_n = DEFEND;
            end else if (move_l && !move_r) begin
                state_n  = WALK_L;
                facing_n = 1'b0;
                pos_n    = step_sat(pos_r, STEP, X_MIN, X_MAX, 1'b0);
            end else if (move_r && !move_l) begin
                state_n  = WALK_R;
                facing_n = 1'b1;
                pos_n    = step_sat(pos_r, STEP, X_MIN, X_MAX, 1'b1);
            end else begin
                state_n = IDLE;
            end
        end else begin
            state_n = state_n;
        end

        case (state_n)
            WALK_L, WALK_R: anim_n = (state_n == state_r) ? {1'b0, anim_r[1:0] + 2'd1} : 3'd0;
            ATTACK:         anim_n = cnt_n[2:0];
            default:        anim_n = 3'd0;
        endcase

        hit_n = (state_n == ATTACK) && (cnt_n >= HIT_FRAME);
`ifdef CHARACTER_DEFENSE_EN
        block_n = (state_n == DEFEND);
`else
        block_n = 1'b0;
`endif
    end

    // Frame-rate state register; reset overrides a coincident tick.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r  <= IDLE;
            pos_r    <= X_INIT;
            facing_r <= FACE_INIT;
            cnt_r    <= 4'd0;
            armed_r  <= 1'b1;
            anim_r   <= 3'd0;
            hit_r    <= 1'b0;
            block_r  <= 1'b0;
        end else if (tick_s) begin
            state_r  <= state_n;
            pos_r    <= pos_n;
            facing_r <= facing_n;
            cnt_r    <= cnt_n;
            armed_r  <= armed_n;
            anim_r   <= anim_n;
            hit_r    <= hit_n;
            block_r  <= block_n;
        end
    end

    assign pos_x      = pos_r;
    assign facing     = facing_r;
    assign state      = state_r;
    assign anim_frame = anim_r;
    assign hit_active = hit_r;
    assign blocking   = block_r;

endmodule

// File: tb/tb_character_fsm.sv
// Directed self-checking bench for character_fsm (default and edge-position instances).
module tb_character_fsm;

    logic       Clk;
    logic       Reset;
    logic       frame_clk;
    logic       move_l;
    logic       move_r;
    logic       attack;
    logic       defense;

    logic [9:0] pos_x,  pos_hi,  pos_lo;
    logic       facing, face_hi, face_lo;
    logic [2:0] state,  st_hi,   st_lo;
    logic [2:0] anim,   anim_hi, anim_lo;
    logic       hit,    hit_hi,  hit_lo;
    logic       blk,    blk_hi,  blk_lo;

    int checks   = 0;
    int failures = 0;

    localparam logic [2:0] S_IDLE = 3'd0, S_WL = 3'd1, S_WR = 3'd2,
                           S_ATK = 3'd3, S_REC = 3'd4, S_DEF = 3'd5;

    character_fsm dut (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .move_l(move_l), .move_r(move_r),
        .attack(attack), .defense(defense), .pos_x(pos_x), .facing(facing), .state(state),
        .anim_frame(anim), .hit_active(hit), .blocking(blk)
    );

    character_fsm #(.X_INIT(10'd574)) dut_hi (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .move_l(move_l), .move_r(move_r),
        .attack(attack), .defense(defense), .pos_x(pos_hi), .facing(face_hi), .state(st_hi),
        .anim_frame(anim_hi), .hit_active(hit_hi), .blocking(blk_hi)
    );

    character_fsm #(.X_INIT(10'd2)) dut_lo (
        .Clk(Clk), .Reset(Reset), .frame_clk(frame_clk), .move_l(move_l), .move_r(move_r),
        .attack(attack), .defense(defense), .pos_x(pos_lo), .facing(face_lo), .state(st_lo),
        .anim_frame(anim_lo), .hit_active(hit_lo), .blocking(blk_lo)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
    endtask

    task automatic do_tick();
        frame_clk = 1'b1;
        repeat (4) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    initial begin
        Reset = 1'b1; frame_clk = 1'b0;
        move_l = 1'b0; move_r = 1'b0; attack = 1'b0; defense = 1'b0;
        @(negedge Clk);
        do_reset();

        chk("rst_pos",    pos_x, 160);
        chk("rst_state",  state, S_IDLE);
        chk("rst_facing", facing, 1);
        chk("rst_anim",   anim, 0);
        chk("rst_hit",    hit, 0);
        chk("rst_blk",    blk, 0);

        repeat (3) do_tick();
        chk("idle_pos",    pos_x, 160);
        chk("idle_state",  state, S_IDLE);
        chk("idle_facing", facing, 1);
        chk("idle_flags",  {hit, blk, anim}, 0);

        // Walk right five frames; animation wraps after 3.
        move_r = 1'b1;
        for (int t = 0; t < 5; t++) begin
            do_tick();
            chk($sformatf("wr_anim_t%0d", t), anim, t % 4);
            chk($sformatf("wr_pos_t%0d", t), pos_x, 160 + 4 * (t + 1));
        end
        chk("wr_state",   state, S_WR);
        chk("wr_facing",  facing, 1);
        chk("hi_sat_pos", pos_hi, 576);
        chk("hi_state",   st_hi, S_WR);
        chk("lo_pos",     pos_lo, 22);

        // Both directions held: idle, no motion.
        move_l = 1'b1;
        repeat (2) do_tick();
        chk("both_state", state, S_IDLE);
        chk("both_pos",   pos_x, 180);
        chk("both_anim",  anim, 0);

        // Walk left from x=2 clamps at 0.
        move_r = 1'b0;
        do_reset();
        repeat (2) do_tick();
        chk("lo_sat_pos", pos_lo, 0);
        chk("lo_state",   st_lo, S_WL);
        chk("lo_facing",  face_lo, 0);
        chk("wl_pos",     pos_x, 152);

        // Held attack: 8 ATTACK, 6 RECOVER, then IDLE without re-triggering.
        move_l = 1'b0;
        do_reset();
        attack = 1'b1;
        begin
            int hits;
            hits = 0;
            for (int t = 1; t <= 20; t++) begin
                do_tick();
                if (hit) hits++;
                if (t <= 8) begin
                    chk($sformatf("atk_state_t%0d", t), state, S_ATK);
                    chk($sformatf("atk_anim_t%0d", t), anim, t - 1);
                    chk($sformatf("atk_hit_t%0d", t), hit, (t - 1 >= 3) ? 1 : 0);
                end else if (t <= 14) begin
                    chk($sformatf("rec_state_t%0d", t), state, S_REC);
                    chk($sformatf("rec_hit_t%0d", t), hit, 0);
                end else begin
                    chk($sformatf("post_state_t%0d", t), state, S_IDLE);
                end
            end
            chk("atk_hit_count", hits, 5);
        end
        chk("atk_pos", pos_x, 160);
        attack = 1'b0;
        do_tick();
        chk("rearm_idle", state, S_IDLE);
        attack = 1'b1;
        do_tick();
        chk("rearm_atk", state, S_ATK);

        // Reset while ATTACK counter is 4.
        attack = 1'b0;
        do_reset();
        attack = 1'b1;
        repeat (5) do_tick();
        chk("mid_atk_anim", anim, 4);
        chk("mid_atk_hit",  hit, 1);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk("abort_state", state, S_IDLE);
        chk("abort_hit",   hit, 0);
        chk("abort_pos",   pos_x, 160);
        attack = 1'b0;

        // frame_clk held high for many clocks yields a single step.
        do_reset();
        move_r = 1'b1;
        frame_clk = 1'b1;
        repeat (40) @(negedge Clk);
        chk("hold_pos",   pos_x, 164);
        chk("hold_state", state, S_WR);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);

        // Defense with move_r, then attack overriding defense.
        do_reset();
        defense = 1'b1;
        repeat (3) do_tick();
`ifdef CHARACTER_DEFENSE_EN
        chk("def_state", state, S_DEF);
        chk("def_blk",   blk, 1);
        chk("def_pos",   pos_x, 160);
`else
        chk("def_state", state, S_WR);
        chk("def_blk",   blk, 0);
        chk("def_pos",   pos_x, 172);
`endif
        attack = 1'b1;
        do_tick();
        chk("def_atk_state", state, S_ATK);
        chk("def_atk_blk",   blk, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
